alu_seq_hs: RTL

//  Parametrised, clocked successor to the 4-bit combinational lab ALU: N-bit operands, valid/ready handshake,

---
 rtl/alu_seq_pkg.sv | 29 ++
 rtl/hex_to_7seg.sv | 11 +
 rtl/alu_seq_hs.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the sequential handshake ALU (alu_seq_hs).
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_SRL = 3'd2,
    OP_SLL = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_MUL = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  // Active-low segments {g,f,e,d,c,b,a}; entry 15 first so SEG_TABLE[nibble] indexes naturally.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,  // F E d C
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,  // b A 9 8
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,  // 7 6 5 4
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000   // 3 2 1 0
  };

endpackage

// File: rtl/hex_to_7seg.sv
// One hex nibble to one active-low seven-segment digit, pure combinational lookup.
module hex_to_7seg
  import alu_seq_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/alu_seq_hs.sv
// Sequential N-bit ALU with valid/ready handshake, bit-serial shifts and NZCV flags.
// Define ALU_MUL_EN to build the shift-add multiplier on op 7; otherwise op 7 is reserved.
module alu_seq_hs
  import alu_seq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               a,
  input  logic [N-1:0]               b,
  input  logic [2:0]                 op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               result,
  output logic                       flag_n,
  output logic                       flag_z,
  output logic                       flag_c,
  output logic                       flag_v,
  output logic [7*((N+3)/4)-1:0]     seg
);

  localparam int SHW    = $clog2(N);
  localparam int DIGITS = (N + 3) / 4;
  localparam int CW     = $clog2(N + 1);

  state_t         state_q, state_d;
  alu_op_t        op_q, op_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sc_q, sc_d;
  logic [N-1:0]   result_q, result_d;
  logic           fn_q, fn_d, fz_q, fz_d, fc_q, fc_d, fv_q, fv_d;
`ifdef ALU_MUL_EN
  logic [2*N-1:0] prod_q, prod_d, mcand_q, mcand_d, prod_nxt;
`endif

  logic           fin;
  logic [N-1:0]   res;
  logic           res_c, res_v;
  logic [N:0]     sum, diff;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sc_d     = sc_q;
    result_d = result_q;
    fn_d     = fn_q;
    fz_d     = fz_q;
    fc_d     = fc_q;
    fv_d     = fv_q;
    fin      = 1'b0;
    res      = '0;
    res_c    = 1'b0;
    res_v    = 1'b0;
    sum      = {1'b0, a_q} + {1'b0, b_q};
    diff     = {1'b0, a_q} - {1'b0, b_q};
`ifdef ALU_MUL_EN
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    prod_nxt = prod_q + (b_q[0] ? mcand_q : '0);
`endif

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d  = alu_op_t'(op);
          a_d   = a;
          b_d   = b;
          acc_d = a;
          sc_d  = 1'b0;
          cnt_d = CW'(b[SHW-1:0]);
`ifdef ALU_MUL_EN
          if (alu_op_t'(op) == OP_MUL) cnt_d = CW'(N);
          prod_d  = '0;
          mcand_d = {{N{1'b0}}, a};
`endif
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        case (op_q)
          OP_ADD: begin
            fin   = 1'b1;
            res   = sum[N-1:0];
            res_c = sum[N];
            res_v = (a_q[N-1] == b_q[N-1]) && (sum[N-1] != a_q[N-1]);
          end
          OP_SUB: begin
            fin   = 1'b1;
            res   = diff[N-1:0];
            res_c = ~diff[N];  // no borrow means a >= b
            res_v = (a_q[N-1] != b_q[N-1]) && (diff[N-1] != a_q[N-1]);
          end
          OP_SRL, OP_SLL: begin
            if (cnt_q == '0) begin
              fin = 1'b1;
              res = acc_q;
            end else begin
              if (op_q == OP_SLL) begin
                sc_d  = acc_q[N-1];
                acc_d = {acc_q[N-2:0], 1'b0};
              end else begin
                sc_d  = acc_q[0];
                acc_d = {1'b0, acc_q[N-1:1]};
              end
              cnt_d = cnt_q - CW'(1);
              if (cnt_q == CW'(1)) begin
                fin   = 1'b1;
                res   = acc_d;
                res_c = sc_d;
              end
            end
          end
          OP_AND: begin fin = 1'b1; res = a_q & b_q; end
          OP_OR:  begin fin = 1'b1; res = a_q | b_q; end
          OP_XOR: begin fin = 1'b1; res = a_q ^ b_q; end
          OP_MUL: begin
`ifdef ALU_MUL_EN
            // One multiplier bit per cycle: add the shifted multiplicand when the LSB is set.
            prod_d  = prod_nxt;
            mcand_d = mcand_q << 1;
            b_d     = b_q >> 1;
            cnt_d   = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              fin   = 1'b1;
              res   = prod_nxt[N-1:0];
              res_c = |prod_nxt[2*N-1:N];
              res_v = res_c;
            end
`else
            fin = 1'b1;
`endif
          end
          default: fin = 1'b1;
        endcase

        if (fin) begin
          result_d = res;
          fn_d     = res[N-1];
          fz_d     = (res == '0);
          fc_d     = res_c;
          fv_d     = res_v;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  // NOTE: every register, datapath included, is reset so an in-flight op is fully discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sc_q     <= 1'b0;
      result_q <= '0;
      fn_q     <= 1'b0;
      fz_q     <= 1'b0;
      fc_q     <= 1'b0;
      fv_q     <= 1'b0;
`ifdef ALU_MUL_EN
      prod_q   <= '0;
      mcand_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sc_q     <= sc_d;
      result_q <= result_d;
      fn_q     <= fn_d;
      fz_q     <= fz_d;
      fc_q     <= fc_d;
      fv_q     <= fv_d;
`ifdef ALU_MUL_EN
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign flag_n    = fn_q;
  assign flag_z    = fz_q;
  assign flag_c    = fc_q;
  assign flag_v    = fv_q;

  // Display follows the result register itself, independent of out_valid.
  logic [4*DIGITS-1:0] res_ext;
  always_comb begin
    res_ext        = '0;
    res_ext[N-1:0] = result_q;
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    hex_to_7seg u_hex (
      .nibble (res_ext[4*k +: 4]),
      .seg    (seg[7*k +: 7])
    );
  end

endmodule
